cpu_regfile: RTL and testbench

Parametrised primary register file for the CPU datapath. Replaces the single-port, bus-only register bank with two registered read ports, one dedicated write port and a shared-bus load/drive port. Write-to-read bypass and a per-register busy scoreboard let the control FSM issue back-to-back instructions without re-reading the bus. Sits between the instruction decoder/FSM and the shared 8-bit data bus; the tri-state driver stays at the top level.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/cpu_regfile_rdport.sv | 51 +++++
 rtl/cpu_regfile.sv | 131 +++++++++++++
 tb/tb_cpu_regfile.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and default sizes.
// Imported by the register file and its read-port sub-module.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned NREGS_DEF  = 8;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0]        reg_data_t;

endpackage

// File: rtl/cpu_regfile_rdport.sv
// Registered read port with same-cycle write bypass and hold-on-disable.
// The dedicated write port outranks the bus-load port when both hit the read address.
module cpu_regfile_rdport
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [AW-1:0]                  addr,
    input  logic [NREGS-1:0][DATA_W-1:0]   regs,
    input  logic                           wp_en,
    input  logic [AW-1:0]                  wp_addr,
    input  logic [DATA_W-1:0]              wp_data,
    input  logic                           bp_en,
    input  logic [AW-1:0]                  bp_addr,
    input  logic [DATA_W-1:0]              bp_data,
    output logic [DATA_W-1:0]              data
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Enables arrive already qualified, so a dropped write never bypasses.
    always_comb begin
        data_d = data_q;
        if (en) begin
            if (wp_en && (wp_addr == addr)) begin
                data_d = wp_data;
            end else if (bp_en && (bp_addr == addr)) begin
                data_d = bp_data;
            end else begin
                data_d = regs[addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/cpu_regfile.sv
// CPU primary register file: two registered read ports, a write port, a bus
// load/drive port and a per-register busy scoreboard.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_a_en,
    input  logic [AW-1:0]     rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic              rd_b_en,
    input  logic [AW-1:0]     rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              bus_load,
    input  logic              bus_drive,
    input  logic [AW-1:0]     bus_addr,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;
    logic [NREGS-1:0]             busy_q;
    logic [NREGS-1:0]             busy_d;

    logic wr_commit;
    logic bus_commit;
    logic wr_r0_hit;
    logic bus_r0_hit;
    logic rsv_r0_hit;

    assign wr_r0_hit  = ZERO_R0 && (wr_addr == '0);
    assign bus_r0_hit = ZERO_R0 && (bus_addr == '0);
    assign rsv_r0_hit = ZERO_R0 && (rsv_addr == '0);

    // The write port wins an address collision; the bus value is dropped.
    assign wr_commit  = wr_en && !wr_r0_hit;
    assign bus_commit = bus_load && !bus_r0_hit && !(wr_en && (wr_addr == bus_addr));

    always_comb begin
        regs_d = regs_q;
        if (bus_commit) begin
            regs_d[bus_addr] = bus_in;
        end
        if (wr_commit) begin
            regs_d[wr_addr] = wr_data;
        end
        if (ZERO_R0) begin
            regs_d[0] = '0;
        end
    end

    // A reservation in the same cycle as a write leaves the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if ((wr_commit && (wr_addr == AW'(i))) || (bus_commit && (bus_addr == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end
            if (rsv_en && !rsv_r0_hit && (rsv_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign bus_out = regs_q[bus_addr];
    assign bus_oe  = bus_drive && !bus_load && !rst;

    cpu_regfile_rdport #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rdport_a (
        .clk     (clk),
        .rst     (rst),
        .en      (rd_a_en),
        .addr    (rd_a_addr),
        .regs    (regs_q),
        .wp_en   (wr_commit),
        .wp_addr (wr_addr),
        .wp_data (wr_data),
        .bp_en   (bus_commit),
        .bp_addr (bus_addr),
        .bp_data (bus_in),
        .data    (rd_a_data)
    );

    cpu_regfile_rdport #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rdport_b (
        .clk     (clk),
        .rst     (rst),
        .en      (rd_b_en),
        .addr    (rd_b_addr),
        .regs    (regs_q),
        .wp_en   (wr_commit),
        .wp_addr (wr_addr),
        .wp_data (wr_data),
        .bp_en   (bus_commit),
        .bp_addr (bus_addr),
        .bp_data (bus_in),
        .data    (rd_b_data)
    );

endmodule

// File: tb/tb_cpu_regfile.sv
// Bench for cpu_regfile: one instance with ZERO_R0=0 and one with ZERO_R0=1,
// both driven identically and compared against an array-based model.
module tb_cpu_regfile;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_a_en;
    logic [2:0] rd_a_addr;
    logic       rd_b_en;
    logic [2:0] rd_b_addr;
    logic       bus_load;
    logic       bus_drive;
    logic [2:0] bus_addr;
    logic [7:0] bus_in;
    logic       rsv_en;
    logic [2:0] rsv_addr;

    logic [7:0] rd_a_data [2];
    logic [7:0] rd_b_data [2];
    logic [7:0] bus_out   [2];
    logic       bus_oe    [2];
    logic [7:0] busy      [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, index 0 = plain instance, 1 = zero-r0 instance.
    logic [7:0] m_regs [2][8];
    logic       m_busy [2][8];
    logic [7:0] m_a    [2];
    logic [7:0] m_b    [2];

    cpu_regfile #(.DATA_W(8), .NREGS(8), .ZERO_R0(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data[0]),
        .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data[0]),
        .bus_load(bus_load), .bus_drive(bus_drive), .bus_addr(bus_addr),
        .bus_in(bus_in), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy[0])
    );

    cpu_regfile #(.DATA_W(8), .NREGS(8), .ZERO_R0(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data[1]),
        .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data[1]),
        .bus_load(bus_load), .bus_drive(bus_drive), .bus_addr(bus_addr),
        .bus_in(bus_in), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pack_busy(input int z);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[z][i];
        return v;
    endfunction

    task automatic idle();
        rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_a_en = 0; rd_a_addr = 0; rd_b_en = 0; rd_b_addr = 0;
        bus_load = 0; bus_drive = 0; bus_addr = 0; bus_in = 0;
        rsv_en = 0; rsv_addr = 0;
    endtask

    // Apply one clock edge's worth of the current inputs to the model.
    task automatic model_update();
        for (int z = 0; z < 2; z++) begin
            logic [7:0] nxt [8];
            bit         hit [8];
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_regs[z][i] = 8'h00;
                    m_busy[z][i] = 1'b0;
                end
                m_a[z] = 8'h00;
                m_b[z] = 8'h00;
            end else begin
                for (int i = 0; i < 8; i++) begin
                    nxt[i] = m_regs[z][i];
                    hit[i] = 1'b0;
                end
                if (bus_load && !(z == 1 && bus_addr == 0)) begin
                    nxt[bus_addr] = bus_in;
                    hit[bus_addr] = 1'b1;
                end
                // Applied last so the dedicated port overrides a same-address bus load.
                if (wr_en && !(z == 1 && wr_addr == 0)) begin
                    nxt[wr_addr] = wr_data;
                    hit[wr_addr] = 1'b1;
                end
                if (rd_a_en) m_a[z] = nxt[rd_a_addr];
                if (rd_b_en) m_b[z] = nxt[rd_b_addr];
                for (int i = 0; i < 8; i++) begin
                    if (hit[i]) m_busy[z][i] = 1'b0;
                    if (rsv_en && rsv_addr == i) m_busy[z][i] = 1'b1;
                    if (z == 1 && i == 0) m_busy[z][i] = 1'b0;
                    m_regs[z][i] = nxt[i];
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already set.
    task automatic tick();
        #1;
        for (int z = 0; z < 2; z++) begin
            check_eq($sformatf("bus_out[%0d]", z), bus_out[z], m_regs[z][bus_addr]);
            check_eq($sformatf("bus_oe[%0d]", z), bus_oe[z], bus_drive && !bus_load && !rst);
        end
        @(posedge clk);
        #1;
        model_update();
        for (int z = 0; z < 2; z++) begin
            check_eq($sformatf("rd_a[%0d]", z), rd_a_data[z], m_a[z]);
            check_eq($sformatf("rd_b[%0d]", z), rd_b_data[z], m_b[z]);
            check_eq($sformatf("busy[%0d]", z), busy[z], pack_busy(z));
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);

        // Reset state, then read every register on both ports.
        idle(); rst = 1; tick();
        check_eq("rst_busy", busy[0], 8'h00);
        for (int i = 0; i < 8; i++) begin
            idle(); rd_a_en = 1; rd_a_addr = 3'(i); rd_b_en = 1; rd_b_addr = 3'(i); tick();
            check_eq("rst_rd_a", rd_a_data[0], 8'h00);
            check_eq("rst_rd_b", rd_b_data[0], 8'h00);
        end

        // Write with same-cycle bypass, then a follow-up read on B.
        idle(); wr_en = 1; wr_addr = 3; wr_data = 8'hA5; rd_a_en = 1; rd_a_addr = 3; tick();
        check_eq("bypass_a", rd_a_data[0], 8'hA5);
        idle(); rd_b_en = 1; rd_b_addr = 3; tick();
        check_eq("after_b", rd_b_data[0], 8'hA5);

        // Write port vs bus load collision, then different targets.
        idle(); wr_en = 1; wr_addr = 5; wr_data = 8'h11; bus_load = 1; bus_addr = 5;
        bus_in = 8'h22; tick();
        idle(); rd_a_en = 1; rd_a_addr = 5; tick();
        check_eq("coll_r5", rd_a_data[0], 8'h11);
        idle(); wr_en = 1; wr_addr = 5; wr_data = 8'h11; bus_load = 1; bus_addr = 6;
        bus_in = 8'h22; tick();
        idle(); rd_a_en = 1; rd_a_addr = 5; rd_b_en = 1; rd_b_addr = 6; tick();
        check_eq("split_r5", rd_a_data[0], 8'h11);
        check_eq("split_r6", rd_b_data[0], 8'h22);

        // Bus drive, then drive+load conflict.
        idle(); wr_en = 1; wr_addr = 2; wr_data = 8'h3C; tick();
        idle(); bus_drive = 1; bus_addr = 2; #1;
        check_eq("drv_out", bus_out[0], 8'h3C);
        check_eq("drv_oe", bus_oe[0], 1'b1);
        tick();
        idle(); bus_drive = 1; bus_load = 1; bus_addr = 2; bus_in = 8'h77; #1;
        check_eq("conf_oe", bus_oe[0], 1'b0);
        tick();
        idle(); rd_a_en = 1; rd_a_addr = 2; tick();
        check_eq("conf_r2", rd_a_data[0], 8'h77);

        // Scoreboard set, clear, and set-wins.
        idle(); rsv_en = 1; rsv_addr = 4; tick();
        check_eq("sb_set", busy[0], 8'h10);
        idle(); wr_en = 1; wr_addr = 4; wr_data = 8'h09; tick();
        check_eq("sb_clr", busy[0], 8'h00);
        idle(); rsv_en = 1; rsv_addr = 4; wr_en = 1; wr_addr = 4; wr_data = 8'h5A; tick();
        check_eq("sb_both", busy[0][4], 1'b1);

        // Register 0 is hard-wired on the ZERO_R0 instance only.
        idle(); wr_en = 1; wr_addr = 0; wr_data = 8'hFF; rsv_en = 1; rsv_addr = 0;
        rd_a_en = 1; rd_a_addr = 0; tick();
        check_eq("z_byp", rd_a_data[1], 8'h00);
        check_eq("z_busy", busy[1][0], 1'b0);
        check_eq("nz_byp", rd_a_data[0], 8'hFF);
        idle(); rd_b_en = 1; rd_b_addr = 0; bus_addr = 0; tick();
        check_eq("z_rd", rd_b_data[1], 8'h00);

        // Reset wins over a same-cycle write, reservation and read.
        idle(); rst = 1; wr_en = 1; wr_addr = 1; wr_data = 8'h55; rsv_en = 1; rsv_addr = 3;
        rd_a_en = 1; rd_a_addr = 1; bus_drive = 1; #1;
        check_eq("rst_oe", bus_oe[1], 1'b0);
        tick();
        for (int z = 0; z < 2; z++) begin
            check_eq("mid_rst_a", rd_a_data[z], 8'h00);
            check_eq("mid_rst_b", rd_b_data[z], 8'h00);
            check_eq("mid_rst_busy", busy[z], 8'h00);
        end
        idle(); rd_a_en = 1; rd_a_addr = 1; tick();
        check_eq("mid_rst_r1", rd_a_data[1], 8'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            wr_en     = $urandom_range(0, 1);
            wr_addr   = 3'($urandom);
            wr_data   = 8'($urandom);
            rd_a_en   = $urandom_range(0, 1);
            rd_a_addr = 3'($urandom);
            rd_b_en   = $urandom_range(0, 1);
            rd_b_addr = 3'($urandom);
            bus_load  = ($urandom_range(0, 2) == 0);
            bus_drive = $urandom_range(0, 1);
            bus_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            bus_in    = 8'($urandom);
            rsv_en    = ($urandom_range(0, 2) == 0);
            rsv_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
